bcd_entry: RTL and testbench
============================

# bcd_entry

Button-driven entry block that builds the 10-digit BCD operand and the 4-bit mode code consumed by the seven-segment display driver and the RSA datapath. It synchronizes and debounces five raw push-buttons, moves an edit cursor over ten digit positions plus a mode position, increments or decrements the selected field, and emits a one-cycle commit strobe when the user confirms. It is the writer side of the `BCD`/`mode` interface that the display block reads.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: cycles an input must hold a new level before it is accepted (10 ms at 100 MHz); legal range 2..2^20.
- `MODE_COUNT`, default 3: number of legal mode codes, 0..MODE_COUNT-1; legal range 1..10.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_up`  in  1  raw button, increment the field under the cursor.
- `btn_down`  in  1  raw button, decrement the field under the cursor.
- `btn_left`  in  1  raw button, move the cursor toward the more-significant field.
- `btn_right`  in  1  raw button, move the cursor toward the less-significant field.
- `btn_center`  in  1  raw button, commit.
- `BCD`  out  40  entered number, digit k at bits [4k+3:4k], k=0 least significant.
- `mode`  out  4  selected mode code.
- `cursor`  out  4  edit position: 0..9 are digits, 10 is the mode field.
- `commit`  out  1  one-cycle strobe, `BCD`/`mode` valid and stable.

## Operation
- Per button: a 2-FF synchronizer, then a debouncer. The debouncer holds a `stable` bit and a counter. The counter clears whenever the synchronized level equals `stable`. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, `stable` takes the synchronized level and the counter clears.
- A press event is a one-cycle pulse on a 0->1 transition of `stable`. Releases generate no event.
- At most one event is applied per cycle. Priority: center > up > down > left > right. Lower-priority events in the same cycle are discarded, not queued.
- up, cursor 0..9: the selected digit increments; 9 wraps to 0. No carry into neighbouring digits.
- down, cursor 0..9: the selected digit decrements; 0 wraps to 9.
- up, cursor 10: `mode` increments; MODE_COUNT-1 wraps to 0.
- down, cursor 10: `mode` decrements; 0 wraps to MODE_COUNT-1.
- left: cursor increments; 10 wraps to 0.
- right: cursor decrements; 0 wraps to 10.
- center: `commit` pulses. `BCD`, `mode` and `cursor` are unchanged.
- Invariants: every digit of `BCD` is always 0..9, and `mode` is always below MODE_COUNT.

## Timing
- Reset values: `BCD`=0, `mode`=0, `cursor`=0, `commit`=0. All synchronizer, debounce and `stable` state is also 0.
- Reset is asynchronous. Asserting it mid-debounce or mid-edit discards all progress. A button held through reset release counts as a fresh press once it has been stable for DEBOUNCE_CYCLES.
- Latency from a clean input edge to the press pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles.
- `BCD`, `mode` and `cursor` update on the clock edge after the press pulse. `commit` is asserted in that same cycle, for exactly one cycle.
- Bounce shorter than DEBOUNCE_CYCLES produces no event. A held button produces exactly one event.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- DEBOUNCE_CYCLES=4, MODE_COUNT=3. Reset, then press up 3 times -> `BCD`=40'h0000000003 and `cursor`=0. Press down 4 times -> digit 0 is 9, `BCD`=40'h0000000009.
- Press left 9 times -> `cursor`=9. Up -> `BCD[39:36]`=1. Left -> `cursor`=10. Left again -> `cursor`=0. Right -> `cursor`=10.
- With cursor=10: up ×3 -> `mode` goes 1, 2, 0. Down -> `mode`=2. `BCD` is unchanged throughout.
- Toggle btn_up for 3-cycle pulses with 2-cycle gaps for 40 cycles, then release -> no change. Hold btn_up for 100 cycles -> exactly one increment, first visible 7 cycles after the input edge.
- btn_center and btn_up rise on the same cycle -> one `commit` pulse, digit unchanged. Hold up alone afterwards -> an increment only after release and a new press.
- Assert `rst` for 1 cycle mid-debounce with `BCD`=40'h0000000305 and `mode`=2 -> all outputs return to 0 immediately, and the interrupted press produces no event.

Source files
------------

// File: rtl/bcd_entry.sv
// bcd_entry: debounced five-button editor for a 10-digit BCD operand and a mode code.
module bcd_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MODE_COUNT      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [39:0] BCD,
  output logic [3:0]  mode,
  output logic [3:0]  cursor,
  output logic        commit
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned DIGITS  = 10;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       MODE_LAST   = 4'(MODE_COUNT - 1);
  localparam logic [3:0]       CURSOR_MODE = 4'd10;

  // Bit positions of each button in the packed button vectors.
  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_CENTER = 4;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync_a;
  logic [NUM_BTN-1:0] sync_b;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press;
  logic [CNT_W-1:0]   cnt [NUM_BTN];

  logic [39:0] bcd_q,    bcd_n;
  logic [3:0]  mode_q,   mode_n;
  logic [3:0]  cursor_q, cursor_n;
  logic        commit_q, commit_n;

  assign btn_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

  // Two-flop synchronizer for the raw buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Debouncer per button; press is a registered one-cycle pulse on an accepted 0->1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      press <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (sync_b[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_b[i];
          press[i]  <= sync_b[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edit state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q    <= '0;
      mode_q   <= '0;
      cursor_q <= '0;
      commit_q <= 1'b0;
    end else begin
      bcd_q    <= bcd_n;
      mode_q   <= mode_n;
      cursor_q <= cursor_n;
      commit_q <= commit_n;
    end
  end

  // Apply the highest-priority press event; others in the same cycle are dropped.
  always_comb begin
    bcd_n    = bcd_q;
    mode_n   = mode_q;
    cursor_n = cursor_q;
    commit_n = 1'b0;
    if (press[BTN_CENTER]) begin
      commit_n = 1'b1;
    end else if (press[BTN_UP]) begin
      if (cursor_q == CURSOR_MODE) begin
        mode_n = (mode_q == MODE_LAST) ? 4'd0 : mode_q + 4'd1;
      end else begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          if (cursor_q == 4'(k)) begin
            bcd_n[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd9) ? 4'd0 : bcd_q[4*k +: 4] + 4'd1;
          end
        end
      end
    end else if (press[BTN_DOWN]) begin
      if (cursor_q == CURSOR_MODE) begin
        mode_n = (mode_q == 4'd0) ? MODE_LAST : mode_q - 4'd1;
      end else begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          if (cursor_q == 4'(k)) begin
            bcd_n[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd0) ? 4'd9 : bcd_q[4*k +: 4] - 4'd1;
          end
        end
      end
    end else if (press[BTN_LEFT]) begin
      cursor_n = (cursor_q == CURSOR_MODE) ? 4'd0 : cursor_q + 4'd1;
    end else if (press[BTN_RIGHT]) begin
      cursor_n = (cursor_q == 4'd0) ? CURSOR_MODE : cursor_q - 4'd1;
    end
  end

  assign BCD    = bcd_q;
  assign mode   = mode_q;
  assign cursor = cursor_q;
  assign commit = commit_q;

endmodule

// File: tb/tb_bcd_entry.sv
// tb_bcd_entry: directed and randomized button sequences checked against a digit-array model.
module tb_bcd_entry;

  localparam int unsigned DEB = 4;
  localparam int unsigned MC  = 3;

  localparam int B_UP     = 0;
  localparam int B_DOWN   = 1;
  localparam int B_LEFT   = 2;
  localparam int B_RIGHT  = 3;
  localparam int B_CENTER = 4;

  logic        clk;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [39:0] BCD;
  logic [3:0]  mode;
  logic [3:0]  cursor;
  logic        commit;

  int n_checks;
  int n_pass;

  // Reference model: plain digit array, mode and cursor positions.
  int digits [10];
  int m_mode;
  int m_cursor;

  bcd_entry #(.DEBOUNCE_CYCLES(DEB), .MODE_COUNT(MC)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .BCD        (BCD),
    .mode       (mode),
    .cursor     (cursor),
    .commit     (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [39:0] model_bcd();
    logic [39:0] r;
    r = '0;
    for (int k = 9; k >= 0; k--) r = r * 40'd16 + 40'(digits[k]);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 10; k++) digits[k] = 0;
    m_mode   = 0;
    m_cursor = 0;
  endtask

  task automatic model_apply(input int b);
    case (b)
      B_UP:    if (m_cursor == 10) m_mode = (m_mode + 1) % MC;
               else digits[m_cursor] = (digits[m_cursor] + 1) % 10;
      B_DOWN:  if (m_cursor == 10) m_mode = (m_mode + MC - 1) % MC;
               else digits[m_cursor] = (digits[m_cursor] + 9) % 10;
      B_LEFT:  m_cursor = (m_cursor + 1) % 11;
      B_RIGHT: m_cursor = (m_cursor + 10) % 11;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bcd"},    BCD,           model_bcd());
    check({tag, ".mode"},   40'(mode),     40'(m_mode));
    check({tag, ".cursor"}, 40'(cursor),   40'(m_cursor));
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:     btn_up     = v;
      B_DOWN:   btn_down   = v;
      B_LEFT:   btn_left   = v;
      B_RIGHT:  btn_right  = v;
      default:  btn_center = v;
    endcase
  endtask

  // Clean press: hold, release, let both edges settle, then compare with the model.
  task automatic press(input int b, input int hold, input int gap);
    int commits;
    commits = 0;
    set_btn(b, 1'b1);
    repeat (hold) begin @(negedge clk); commits += int'(commit); end
    set_btn(b, 1'b0);
    repeat (gap) begin @(negedge clk); commits += int'(commit); end
    model_apply(b);
    check_all("press");
    check("press.commits", 40'(commits), 40'((b == B_CENTER) ? 1 : 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int commits;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_center = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    check("reset.commit", 40'(commit), 40'd0);
    rst = 1'b0;

    // Digit 0 up and down with wrap.
    repeat (3) press(B_UP, 8, 10);
    check("up3", BCD, 40'h0000000003);
    repeat (4) press(B_DOWN, 8, 10);
    check("down4", BCD, 40'h0000000009);

    // Cursor walk and wrap in both directions.
    repeat (9) press(B_LEFT, 8, 10);
    check("cursor9", 40'(cursor), 40'd9);
    press(B_UP, 8, 10);
    check("top_digit", 40'(BCD[39:36]), 40'd1);
    press(B_LEFT, 8, 10);
    check("cursor10", 40'(cursor), 40'd10);
    press(B_LEFT, 8, 10);
    check("cursor_wrap0", 40'(cursor), 40'd0);
    press(B_RIGHT, 8, 10);
    check("cursor_wrap10", 40'(cursor), 40'd10);

    // Mode field wrap.
    press(B_UP, 8, 10);   check("mode1", 40'(mode), 40'd1);
    press(B_UP, 8, 10);   check("mode2", 40'(mode), 40'd2);
    press(B_UP, 8, 10);   check("mode0", 40'(mode), 40'd0);
    press(B_DOWN, 8, 10); check("mode_down", 40'(mode), 40'd2);
    check("mode_bcd_kept", BCD, 40'h1000000009);

    // Bounce shorter than the debounce window is ignored.
    repeat (8) begin
      btn_up = 1'b1; repeat (3) @(negedge clk);
      btn_up = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_all("bounce");

    // Held button: one event, first visible 7 cycles after the input edge.
    commits = 0;
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    check("latency6.mode", 40'(mode), 40'(m_mode));
    @(negedge clk);
    model_apply(B_UP);
    check("latency7.mode", 40'(mode), 40'(m_mode));
    repeat (93) begin @(negedge clk); commits += int'(commit); end
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check_all("held");
    check("held.commits", 40'(commits), 40'd0);

    // Center and up together: center wins, up is discarded and not re-issued while held.
    press(B_RIGHT, 8, 10);
    commits = 0;
    btn_center = 1'b1; btn_up = 1'b1;
    repeat (15) begin @(negedge clk); commits += int'(commit); end
    btn_center = 1'b0;
    repeat (20) begin @(negedge clk); commits += int'(commit); end
    check("simul.commits", 40'(commits), 40'd1);
    check_all("simul_held");
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check_all("simul_release");
    press(B_UP, 8, 10);

    // Build 0x305 / mode 2, then reset mid-debounce.
    do_reset();
    repeat (5) press(B_UP, 6, 9);
    repeat (2) press(B_LEFT, 6, 9);
    repeat (3) press(B_UP, 6, 9);
    repeat (8) press(B_LEFT, 6, 9);
    repeat (2) press(B_UP, 6, 9);
    check("pre_rst.bcd", BCD, 40'h0000000305);
    check("pre_rst.mode", 40'(mode), 40'd2);
    btn_up = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; btn_up = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.commit", 40'(commit), 40'd0);
    @(negedge clk);
    rst = 1'b0;
    commits = 0;
    repeat (20) begin @(negedge clk); commits += int'(commit); end
    check_all("post_rst");
    check("post_rst.commits", 40'(commits), 40'd0);

    // Button held through reset counts as a fresh press.
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();
    repeat (15) @(negedge clk);
    model_apply(B_UP);
    check_all("held_thru_rst");
    btn_up = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized press sequence.
    for (int i = 0; i < 40; i++) begin
      press(int'($urandom_range(0, 4)), int'($urandom_range(5, 12)), int'($urandom_range(8, 12)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
